// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the 5-stage pipeline and its central controller.
// The controller takes the master modport; the pipeline stages take the slave modport.
interface pipe_ctrl_if;
  // Stage requests and hazard operands
  logic        id_stallreq;
  logic        id_r1_en;
  logic [4:0]  id_r1_addr;
  logic        id_r2_en;
  logic [4:0]  id_r2_addr;
  logic        ex_is_load;
  logic        ex_wreg_en;
  logic [4:0]  ex_wreg_addr;
  logic        ex_stallreq;
  logic        mem_stallreq;
  logic        id_jump_en;
  logic        exc_req;
  logic [31:0] exc_vec;

  // Controller decisions
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        id_in_delayslot;
  logic        bus_err;
  logic [31:0] stall_cycles;

  modport master (
    input  id_stallreq,
    input  id_r1_en,
    input  id_r1_addr,
    input  id_r2_en,
    input  id_r2_addr,
    input  ex_is_load,
    input  ex_wreg_en,
    input  ex_wreg_addr,
    input  ex_stallreq,
    input  mem_stallreq,
    input  id_jump_en,
    input  exc_req,
    input  exc_vec,
    output stall,
    output flush,
    output new_pc,
    output id_in_delayslot,
    output bus_err,
    output stall_cycles
  );

  modport slave (
    output id_stallreq,
    output id_r1_en,
    output id_r1_addr,
    output id_r2_en,
    output id_r2_addr,
    output ex_is_load,
    output ex_wreg_en,
    output ex_wreg_addr,
    output ex_stallreq,
    output mem_stallreq,
    output id_jump_en,
    output exc_req,
    output exc_vec,
    input  stall,
    input  flush,
    input  new_pc,
    input  id_in_delayslot,
    input  bus_err,
    input  stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall arbitration, load-use detection, flush/redirect,
// branch-delay-slot tracking and a MEM bus-wait watchdog.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [31:0] BUS_ERR_VEC = 32'hBFC0_0380
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.master bus
);

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  localparam logic [5:0] StallAll  = 6'b111111;
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallNone = 6'b000000;

  typedef enum logic [1:0] {
    StRun,
    StWaitMem,
    StFlush
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        bus_err_q, bus_err_d;
  logic        ds_q, ds_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic        load_use;
  logic        r1_hit;
  logic        r2_hit;
  logic [5:0]  run_stall;
  logic [5:0]  stall;
  logic        in_flush;

  // Load in EX feeding an ID operand cannot be forwarded in time; r0 never hazards.
  always_comb begin
    r1_hit   = bus.id_r1_en && (bus.id_r1_addr == bus.ex_wreg_addr);
    r2_hit   = bus.id_r2_en && (bus.id_r2_addr == bus.ex_wreg_addr);
    load_use = bus.ex_is_load && bus.ex_wreg_en && (bus.ex_wreg_addr != 5'd0) &&
               (r1_hit || r2_hit);
  end

  always_comb begin
    run_stall = StallNone;
    if (bus.exc_req) begin
      run_stall = StallAll;
    end else if (bus.mem_stallreq) begin
      run_stall = StallMem;
    end else if (bus.ex_stallreq) begin
      run_stall = StallEx;
    end else if (bus.id_stallreq || load_use) begin
      run_stall = StallId;
    end
  end

  // WAIT_MEM uses the same priority: it yields StallMem while the bus wait persists
  // and falls back to the ordinary rules on the cycle the wait drops.
  assign in_flush = (state_q == StFlush);
  assign stall    = in_flush ? StallNone : run_stall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    new_pc_d  = new_pc_q;
    bus_err_d = 1'b0;

    unique case (state_q)
      StRun: begin
        if (bus.exc_req) begin
          state_d  = StFlush;
          new_pc_d = bus.exc_vec;
          cnt_d    = 8'd0;
        end else if (bus.mem_stallreq) begin
          state_d = StWaitMem;
          cnt_d   = 8'd1;
        end
      end

      StWaitMem: begin
        if (bus.exc_req) begin
          state_d  = StFlush;
          new_pc_d = bus.exc_vec;
          cnt_d    = 8'd0;
        end else if (!bus.mem_stallreq) begin
          state_d = StRun;
          cnt_d   = 8'd0;
        end else if (cnt_q == TimeoutCnt) begin
          state_d   = StFlush;
          new_pc_d  = BUS_ERR_VEC;
          bus_err_d = 1'b1;
          cnt_d     = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StFlush: begin
        state_d = StRun;
        cnt_d   = 8'd0;
      end

      default: begin
        state_d = StRun;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Delay-slot flag advances only when ID actually accepts a new instruction.
  always_comb begin
    ds_d = ds_q;
    if (in_flush) begin
      ds_d = 1'b0;
    end else if (!stall[2]) begin
      ds_d = bus.id_jump_en;
    end
  end

  assign stall_cycles_d = stall_cycles_q + {31'd0, |stall};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      cnt_q          <= 8'd0;
      new_pc_q       <= 32'd0;
      bus_err_q      <= 1'b0;
      ds_q           <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      new_pc_q       <= new_pc_d;
      bus_err_q      <= bus_err_d;
      ds_q           <= ds_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall           = stall;
  assign bus.flush           = in_flush;
  assign bus.new_pc          = in_flush ? new_pc_q : 32'd0;
  assign bus.id_in_delayslot = ds_q;
  assign bus.bus_err         = bus_err_q;
  assign bus.stall_cycles    = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a request-level model of the controller.
module tb_pipe_ctrl;

  localparam int unsigned Timeout = 4;
  localparam logic [31:0] BusVec  = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus_if ();

  pipe_ctrl #(
    .MEM_TIMEOUT (Timeout),
    .BUS_ERR_VEC (BusVec)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a flush is "owed" for one cycle after an exception or a too-long bus wait;
  // mem_streak counts consecutive cycles of bus wait since the last resolution.
  bit          m_pend;
  logic [31:0] m_target;
  int          m_streak;
  bit          m_flag;
  bit          m_berr;
  logic [31:0] m_sc;

  logic       lu;
  logic [5:0] prio_st;
  logic [5:0] exp_st;

  assign lu = bus_if.ex_is_load && bus_if.ex_wreg_en && (bus_if.ex_wreg_addr != 5'd0) &&
              ((bus_if.id_r1_en && bus_if.id_r1_addr == bus_if.ex_wreg_addr) ||
               (bus_if.id_r2_en && bus_if.id_r2_addr == bus_if.ex_wreg_addr));
  assign prio_st = bus_if.exc_req ? 6'h3F :
                   bus_if.mem_stallreq ? 6'h1F :
                   bus_if.ex_stallreq ? 6'h0F :
                   (bus_if.id_stallreq || lu) ? 6'h07 : 6'h00;
  assign exp_st = m_pend ? 6'h00 : prio_st;

  always @(posedge clk) begin
    if (rst) begin
      m_pend   <= 1'b0;
      m_target <= 32'd0;
      m_streak <= 0;
      m_flag   <= 1'b0;
      m_berr   <= 1'b0;
      m_sc     <= 32'd0;
    end else begin
      if (exp_st != 6'h00) m_sc <= m_sc + 32'd1;
      m_berr <= 1'b0;
      if (m_pend) begin
        m_pend   <= 1'b0;
        m_flag   <= 1'b0;
        m_streak <= 0;
      end else begin
        if (!exp_st[2]) m_flag <= bus_if.id_jump_en;
        if (bus_if.exc_req) begin
          m_pend   <= 1'b1;
          m_target <= bus_if.exc_vec;
          m_streak <= 0;
        end else if (bus_if.mem_stallreq) begin
          if (m_streak + 1 > int'(Timeout)) begin
            m_pend   <= 1'b1;
            m_target <= BusVec;
            m_berr   <= 1'b1;
            m_streak <= 0;
          end else begin
            m_streak <= m_streak + 1;
          end
        end else begin
          m_streak <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_stall", {26'd0, bus_if.stall}, {26'd0, exp_st});
      check("m_flush", {31'd0, bus_if.flush}, {31'd0, m_pend});
      check("m_new_pc", bus_if.new_pc, m_pend ? m_target : 32'd0);
      check("m_delayslot", {31'd0, bus_if.id_in_delayslot}, {31'd0, m_flag});
      check("m_bus_err", {31'd0, bus_if.bus_err}, {31'd0, m_berr});
      check("m_stall_cycles", bus_if.stall_cycles, m_sc);
    end
  end

  task automatic idle();
    bus_if.id_stallreq  = 1'b0;
    bus_if.id_r1_en     = 1'b0;
    bus_if.id_r1_addr   = 5'd0;
    bus_if.id_r2_en     = 1'b0;
    bus_if.id_r2_addr   = 5'd0;
    bus_if.ex_is_load   = 1'b0;
    bus_if.ex_wreg_en   = 1'b0;
    bus_if.ex_wreg_addr = 5'd0;
    bus_if.ex_stallreq  = 1'b0;
    bus_if.mem_stallreq = 1'b0;
    bus_if.id_jump_en   = 1'b0;
    bus_if.exc_req      = 1'b0;
    bus_if.exc_vec      = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", {26'd0, bus_if.stall}, 32'd0);
    check("rst_flush", {31'd0, bus_if.flush}, 32'd0);
    check("rst_new_pc", bus_if.new_pc, 32'd0);
    check("rst_delayslot", {31'd0, bus_if.id_in_delayslot}, 32'd0);
    check("rst_bus_err", {31'd0, bus_if.bus_err}, 32'd0);
    check("rst_stall_cycles", bus_if.stall_cycles, 32'd0);
    tick();

    // Load-use against r5, then the r0 case that must not stall
    bus_if.ex_is_load = 1'b1; bus_if.ex_wreg_en = 1'b1; bus_if.ex_wreg_addr = 5'd5;
    bus_if.id_r1_en = 1'b1; bus_if.id_r1_addr = 5'd5;
    @(negedge clk);
    check("lu_stall", {26'd0, bus_if.stall}, 32'h07);
    tick();
    bus_if.ex_wreg_addr = 5'd0; bus_if.id_r1_addr = 5'd0;
    @(negedge clk);
    check("lu_r0_stall", {26'd0, bus_if.stall}, 32'h00);
    tick();

    // Short bus wait with a concurrent EX stall
    idle();
    bus_if.mem_stallreq = 1'b1; bus_if.ex_stallreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("memwait_stall", {26'd0, bus_if.stall}, 32'h1F);
      tick();
    end
    idle();
    @(negedge clk);
    check("memwait_end_stall", {26'd0, bus_if.stall}, 32'h00);
    check("memwait_end_flush", {31'd0, bus_if.flush}, 32'd0);
    check("memwait_stall_cycles", bus_if.stall_cycles, 32'd4);
    tick();

    // Bus wait beyond the timeout
    bus_if.mem_stallreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("to_stall", {26'd0, bus_if.stall}, 32'h1F);
      check("to_no_berr", {31'd0, bus_if.bus_err}, 32'd0);
      tick();
    end
    @(negedge clk);
    check("to_flush", {31'd0, bus_if.flush}, 32'd1);
    check("to_new_pc", bus_if.new_pc, 32'hBFC0_0380);
    check("to_flush_stall", {26'd0, bus_if.stall}, 32'h00);
    check("to_berr", {31'd0, bus_if.bus_err}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("to_after_flush", {31'd0, bus_if.flush}, 32'd0);
    check("to_after_berr", {31'd0, bus_if.bus_err}, 32'd0);
    check("to_after_new_pc", bus_if.new_pc, 32'd0);
    check("to_stall_cycles", bus_if.stall_cycles, 32'd9);
    tick();

    // Delay-slot flag: set, held across ID stall, cleared on release
    bus_if.id_jump_en = 1'b1;
    @(negedge clk);
    check("ds_jump_stall", {26'd0, bus_if.stall}, 32'h00);
    tick();
    bus_if.id_jump_en = 1'b0; bus_if.id_stallreq = 1'b1;
    @(negedge clk);
    check("ds_set", {31'd0, bus_if.id_in_delayslot}, 32'd1);
    check("ds_id_stall", {26'd0, bus_if.stall}, 32'h07);
    tick();
    @(negedge clk);
    check("ds_hold1", {31'd0, bus_if.id_in_delayslot}, 32'd1);
    tick();
    bus_if.id_stallreq = 1'b0;
    @(negedge clk);
    check("ds_hold2", {31'd0, bus_if.id_in_delayslot}, 32'd1);
    tick();
    @(negedge clk);
    check("ds_clear", {31'd0, bus_if.id_in_delayslot}, 32'd0);
    tick();

    // Exception: full stall, flush next cycle, delay-slot flag killed by the flush
    bus_if.id_jump_en = 1'b1;
    tick();
    bus_if.id_jump_en = 1'b0; bus_if.exc_req = 1'b1; bus_if.exc_vec = 32'h8000_0180;
    @(negedge clk);
    check("exc_stall", {26'd0, bus_if.stall}, 32'h3F);
    check("exc_ds_held", {31'd0, bus_if.id_in_delayslot}, 32'd1);
    tick();
    bus_if.exc_req = 1'b0; bus_if.exc_vec = 32'd0; bus_if.id_jump_en = 1'b1;
    @(negedge clk);
    check("exc_flush", {31'd0, bus_if.flush}, 32'd1);
    check("exc_new_pc", bus_if.new_pc, 32'h8000_0180);
    check("exc_flush_stall", {26'd0, bus_if.stall}, 32'h00);
    tick();
    bus_if.id_jump_en = 1'b0;
    @(negedge clk);
    check("exc_ds_cleared", {31'd0, bus_if.id_in_delayslot}, 32'd0);
    check("exc_after_flush", {31'd0, bus_if.flush}, 32'd0);
    tick();

    // Reset while waiting on the bus with three wait cycles counted
    bus_if.mem_stallreq = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.mem_stallreq = 1'b0;
    @(negedge clk);
    check("rstw_stall", {26'd0, bus_if.stall}, 32'd0);
    check("rstw_flush", {31'd0, bus_if.flush}, 32'd0);
    check("rstw_new_pc", bus_if.new_pc, 32'd0);
    check("rstw_bus_err", {31'd0, bus_if.bus_err}, 32'd0);
    check("rstw_stall_cycles", bus_if.stall_cycles, 32'd0);
    tick();

    // Random traffic; bus waits are sticky so timeouts occur
    for (int i = 0; i < 3000; i++) begin
      bus_if.id_stallreq  = ($urandom_range(7) == 0);
      bus_if.id_r1_en     = $urandom_range(1) == 1;
      bus_if.id_r1_addr   = 5'($urandom_range(3));
      bus_if.id_r2_en     = $urandom_range(1) == 1;
      bus_if.id_r2_addr   = 5'($urandom_range(3));
      bus_if.ex_is_load   = ($urandom_range(2) == 0);
      bus_if.ex_wreg_en   = $urandom_range(3) != 0;
      bus_if.ex_wreg_addr = 5'($urandom_range(3));
      bus_if.ex_stallreq  = ($urandom_range(7) == 0);
      if ($urandom_range(5) == 0) bus_if.mem_stallreq = ~bus_if.mem_stallreq;
      bus_if.id_jump_en   = ($urandom_range(3) == 0);
      bus_if.exc_req      = ($urandom_range(19) == 0);
      bus_if.exc_vec      = $urandom;
      rst                 = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
